if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 108 ++++++++++
 tb/tb_if_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: holds the PC, requests words from instruction memory
// and presents one fetched instruction at a time to the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        mem_stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StReady, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] target_q, target_d;

  logic        adv;
  logic [31:0] branch_tgt;

  assign adv        = ~stall_i & ~mem_stall_i;
  assign branch_tgt = {branch_target_i[31:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack_i) begin
          if (branch_i) begin
            pc_d = branch_tgt;
          end else begin
            instr_d  = imem_data_i;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            state_d  = StReady;
          end
        end else if (branch_i) begin
          // The outstanding request cannot be withdrawn; wait for its ack.
          target_d = branch_tgt;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (branch_i) target_d = branch_tgt;
        if (imem_ack_i) begin
          pc_d    = branch_i ? branch_tgt : target_q;
          state_d = StFetch;
        end
      end
      StReady: begin
        if (branch_i || adv) begin
          pc_d    = branch_i ? branch_tgt : pc_q + 32'd4;
          valid_d = 1'b0;
          instr_d = 32'h0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      pc_out_q <= 32'h0;
      instr_q  <= 32'h0;
      valid_q  <= 1'b0;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  // During a drain pc_q still holds the original address, keeping it stable.
  assign imem_req_o  = (state_q == StFetch) || (state_q == StDrain);
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_out_q;
  assign instr_o     = instr_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a default instance plus one with RESET_PC at the
// top of the address space to exercise PC wrap-around.
module tb_if_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, stall_i, mem_stall_i, branch_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o, instr_o;
  logic        valid_o;

  logic        start_w, ack_w;
  logic        req_w, valid_w;
  logic [31:0] addr_w, pc_w, instr_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  if_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .mem_stall_i(mem_stall_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i), .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_w), .stall_i(stall_i),
    .mem_stall_i(mem_stall_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ack_i(ack_w),
    .imem_data_i(imem_data_i), .pc_o(pc_w), .instr_o(instr_w), .valid_o(valid_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, ".req"}, {31'h0, imem_req_o}, {31'h0, req});
    if (req) check({tag, ".addr"}, imem_addr_o, addr);
    check({tag, ".valid"}, {31'h0, valid_o}, {31'h0, vld});
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".instr"}, instr_o, ins);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0; stall_i = 1'b0; mem_stall_i = 1'b0; branch_i = 1'b0;
    branch_target_i = 32'h0; imem_ack_i = 1'b0; imem_data_i = 32'h0;
    start_w = 1'b0; ack_w = 1'b0;
    #2;
    check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check("reset.pc_q", imem_addr_o, 32'h0);
    check("reset.wrap_pc_q", addr_w, 32'hFFFF_FFFC);
    step();
    rst_i = 1'b0;
    step();
    check_out("idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Basic fetch at address 0, ack one cycle after the request.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_out("fetch0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    imem_ack_i = 1'b1; imem_data_i = 32'hAAAA_0001;
    step();
    imem_ack_i = 1'b0;
    check_out("ready0", 1'b0, 32'h0, 1'b1, 32'h0, 32'hAAAA_0001);

    // Hold in READY under stall then mem_stall.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 1'b0, 32'h0, 1'b1, 32'h0, 32'hAAAA_0001);
    end
    stall_i = 1'b0; mem_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_out("mstall", 1'b0, 32'h0, 1'b1, 32'h0, 32'hAAAA_0001);
    end
    mem_stall_i = 1'b0;
    step();
    check_out("release", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);

    // Zero-wait fetches at 4, 8, 0xC: two cycles per instruction.
    for (int i = 1; i <= 3; i++) begin
      imem_ack_i = 1'b1; imem_data_i = 32'h1000_0000 + i;
      step();
      imem_ack_i = 1'b0;
      check_out("seq.ready", 1'b0, 32'h0, 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i));
      step();
      check_out("seq.fetch", 1'b1, 32'(4 * i + 4), 1'b0, 32'(4 * i), 32'h0);
    end

    // Branch while request at 0x10 is outstanding, second branch wins.
    branch_i = 1'b1; branch_target_i = 32'h83;
    step();
    check_out("drain1", 1'b1, 32'h10, 1'b0, 32'hC, 32'h0);
    branch_target_i = 32'h200;
    step();
    branch_i = 1'b0;
    check_out("drain2", 1'b1, 32'h10, 1'b0, 32'hC, 32'h0);
    imem_ack_i = 1'b1; imem_data_i = 32'h0000_DEAD;
    step();
    check_out("drain.done", 1'b1, 32'h200, 1'b0, 32'hC, 32'h0);

    // Ack coinciding with a branch in FETCH: data dropped, new request issued.
    imem_data_i = 32'h0000_BEEF; branch_i = 1'b1; branch_target_i = 32'h301;
    step();
    branch_i = 1'b0;
    check_out("fetch.br", 1'b1, 32'h300, 1'b0, 32'hC, 32'h0);
    imem_data_i = 32'h5555_5555;
    step();
    imem_ack_i = 1'b0;
    check_out("ready300", 1'b0, 32'h0, 1'b1, 32'h300, 32'h5555_5555);

    // Branch beats stall in READY.
    stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h40;
    step();
    branch_i = 1'b0;
    check_out("ready.br", 1'b1, 32'h40, 1'b0, 32'h300, 32'h0);
    imem_ack_i = 1'b1; imem_data_i = 32'h7777_7777;
    step();
    // Ack still high in READY must be ignored.
    check_out("ready40", 1'b0, 32'h0, 1'b1, 32'h40, 32'h7777_7777);
    step();
    imem_ack_i = 1'b0;
    check_out("ready.ack", 1'b0, 32'h0, 1'b1, 32'h40, 32'h7777_7777);
    stall_i = 1'b0;
    step();
    check_out("fetch44", 1'b1, 32'h44, 1'b0, 32'h40, 32'h0);

    // Asynchronous reset mid-request, then a late ack.
    #2;
    rst_i = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    rst_i = 1'b0;
    imem_ack_i = 1'b1; imem_data_i = 32'h1234_5678;
    step();
    imem_ack_i = 1'b0;
    check_out("late_ack", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    check_out("stay_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // PC wrap on the RESET_PC=0xFFFFFFFC instance.
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    check("wrap.req", {31'h0, req_w}, 32'h1);
    check("wrap.addr", addr_w, 32'hFFFF_FFFC);
    ack_w = 1'b1; imem_data_i = 32'h9999_0000;
    step();
    ack_w = 1'b0;
    check("wrap.valid", {31'h0, valid_w}, 32'h1);
    check("wrap.pc", pc_w, 32'hFFFF_FFFC);
    check("wrap.instr", instr_w, 32'h9999_0000);
    step();
    check("wrap.req2", {31'h0, req_w}, 32'h1);
    check("wrap.addr2", addr_w, 32'h0);
    check("wrap.bubble", instr_w, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
